// File: rtl/eth_tx_arb.sv
// Two-requester round-robin arbiter feeding the eth_tx payload FIFO: forwards one frame at a
// time, pads short frames, truncates long ones, then holds ownership until transmit and gap end.
module eth_tx_arb #(
  parameter int unsigned pMIN_PAYLOAD = 46,
  parameter int unsigned pMAX_PAYLOAD = 1500,
  parameter int unsigned pIFG_CYCLES  = 48
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Req0_Byte,
  input  logic       Req0_Valid,
  input  logic       Req0_Last,
  output logic       Req0_Ready,
  input  logic [7:0] Req1_Byte,
  input  logic       Req1_Valid,
  input  logic       Req1_Last,
  output logic       Req1_Ready,
  output logic [7:0] Eth_Byte,
  output logic       Eth_Byte_Valid,
  output logic       Eth_Pkt_Rdy,
  input  logic       Tx_En,
  output logic [1:0] Grant,
  output logic       Trunc_Err
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] XFER       = 3'd1;
  localparam logic [2:0] DRAIN      = 3'd2;
  localparam logic [2:0] PAD        = 3'd3;
  localparam logic [2:0] KICK       = 3'd4;
  localparam logic [2:0] WAIT_START = 3'd5;
  localparam logic [2:0] WAIT_END   = 3'd6;
  localparam logic [2:0] IFG        = 3'd7;

  localparam int unsigned IFG_W = $clog2(pIFG_CYCLES + 1);
  localparam logic [10:0] MIN_CNT = 11'(pMIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT = 11'(pMAX_PAYLOAD);
  // The IDLE cycle and the grant cycle complete the gap, so the counter covers the rest.
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(pIFG_CYCLES - 3);

  logic [2:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [7:0]       eth_byte_q, eth_byte_d;
  logic             eth_valid_q, eth_valid_d;
  logic             pkt_rdy_q, pkt_rdy_d;
  logic             trunc_q, trunc_d;

  logic        rx_open;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_byte;
  logic        accept;
  logic [10:0] cnt_inc;

  assign rx_open    = (state_q == XFER) || (state_q == DRAIN);
  assign Req0_Ready = rx_open & grant_q[0];
  assign Req1_Ready = rx_open & grant_q[1];

  assign sel_valid = grant_q[0] ? Req0_Valid : Req1_Valid;
  assign sel_last  = grant_q[0] ? Req0_Last  : Req1_Last;
  assign sel_byte  = grant_q[0] ? Req0_Byte  : Req1_Byte;
  assign accept    = rx_open & sel_valid;
  assign cnt_inc   = byte_cnt_q + 11'd1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    eth_byte_d  = 8'h00;
    eth_valid_d = 1'b0;
    pkt_rdy_d   = 1'b0;
    trunc_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req0_Valid || Req1_Valid) begin
          // rr_ptr_q set means requester 1 holds priority when both ask.
          if (Req0_Valid && (!Req1_Valid || !rr_ptr_q)) grant_d = 2'b01;
          else                                          grant_d = 2'b10;
          byte_cnt_d = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        if (accept) begin
          eth_valid_d = 1'b1;
          eth_byte_d  = sel_byte;
          byte_cnt_d  = cnt_inc;
          if (sel_last) begin
            state_d = (cnt_inc < MIN_CNT) ? PAD : KICK;
          end else if (cnt_inc == MAX_CNT) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (accept && sel_last) state_d = KICK;
      end

      PAD: begin
        eth_valid_d = 1'b1;
        byte_cnt_d  = cnt_inc;
        if (cnt_inc == MIN_CNT) state_d = KICK;
      end

      KICK: begin
        // Registered pulse lands one cycle after the final FIFO write.
        pkt_rdy_d = 1'b1;
        state_d   = WAIT_START;
      end

      WAIT_START: begin
        if (Tx_En) state_d = WAIT_END;
      end

      WAIT_END: begin
        if (!Tx_En) begin
          state_d   = IFG;
          ifg_cnt_d = IFG_LOAD;
        end
      end

      IFG: begin
        if (ifg_cnt_q == '0) begin
          state_d  = IDLE;
          grant_d  = 2'b00;
          rr_ptr_d = grant_q[0];
        end else begin
          ifg_cnt_d = ifg_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      rr_ptr_q    <= 1'b0;
      byte_cnt_q  <= '0;
      ifg_cnt_q   <= '0;
      eth_byte_q  <= 8'h00;
      eth_valid_q <= 1'b0;
      pkt_rdy_q   <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      eth_byte_q  <= eth_byte_d;
      eth_valid_q <= eth_valid_d;
      pkt_rdy_q   <= pkt_rdy_d;
      trunc_q     <= trunc_d;
    end
  end

  assign Eth_Byte       = eth_byte_q;
  assign Eth_Byte_Valid = eth_valid_q;
  assign Eth_Pkt_Rdy    = pkt_rdy_q;
  assign Grant          = grant_q;
  assign Trunc_Err      = trunc_q;

endmodule
